// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and width helpers for the associative instruction cache
// Contents: fill FSM state enum and constant functions deriving beat count and field widths.
package icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } icache_state_e;

    // Field widths that can legitimately be zero are widened to one bit so
    // that port and signal declarations stay legal for every parameter set.
    function automatic int min1(input int w);
        return (w > 0) ? w : 1;
    endfunction

    function automatic int icache_beats(input int line_length, input int fill_w);
        return (line_length * 8) / fill_w;
    endfunction

    function automatic int icache_off_w(input int line_length);
        return $clog2(line_length);
    endfunction

    function automatic int icache_idx_w(input int nsets);
        return min1($clog2(nsets));
    endfunction

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: per-set data, tag and valid storage with read-side match
// Ports: clk, reset_n, flush_all; read side rd_index/rd_tag/rd_word -> match, valid, word;
//        write side wr_index, wr_en/wr_chunk/wr_data (one fill beat), wr_tag with validate,
//        invalidate (drop the line at wr_index when a fill into this way begins).
module icache_way
    import icache_pkg::*;
#(
    parameter int RV                     = 16,
    parameter int PA                     = 22,
    parameter int LINE_LENGTH            = 4,
    parameter int NSETS                  = 4,
    parameter int FILL_W                 = 4,
    parameter int USE_LATCHES_FOR_ICACHE = 1,
    localparam int IXW = icache_idx_w(NSETS),
    localparam int TW  = PA - $clog2(LINE_LENGTH) - $clog2(NSETS),
    localparam int LB  = LINE_LENGTH * 8,
    localparam int WDW = min1($clog2(LINE_LENGTH) - $clog2(RV / 8)),
    localparam int BW  = min1($clog2(LINE_LENGTH * 8 / FILL_W))
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_all,
    input  logic [IXW-1:0]    rd_index,
    input  logic [TW-1:0]     rd_tag,
    input  logic [WDW-1:0]    rd_word,
    input  logic [IXW-1:0]    wr_index,
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_chunk,
    input  logic [FILL_W-1:0] wr_data,
    input  logic [TW-1:0]     wr_tag,
    input  logic              validate,
    input  logic              invalidate,
    output logic              match,
    output logic              valid,
    output logic [RV-1:0]     word
);

    logic [NSETS-1:0] valid_q;
    logic [LB-1:0]    line_w [NSETS];
    logic [TW-1:0]    tag_w  [NSETS];
    logic [LB-1:0]    rd_line;

    for (genvar s = 0; s < NSETS; s++) begin : g_set
        logic [LB-1:0] line_q;
        logic [TW-1:0] tag_q;
        logic          line_we;
        logic          tag_we;

        assign line_we = wr_en && (wr_index == IXW'(s));
        assign tag_we  = validate && (wr_index == IXW'(s));

        if (USE_LATCHES_FOR_ICACHE != 0) begin : g_latch
            // Transparent while clk is low: the beat presented during a cycle
            // is captured before the posedge that advances the fill FSM.
            always_latch begin
                if (!clk && line_we) begin
                    line_q[wr_chunk*FILL_W +: FILL_W] = wr_data;
                end
                if (!clk && tag_we) begin
                    tag_q = wr_tag;
                end
            end
        end else begin : g_flop
            always_ff @(posedge clk) begin
                if (line_we) begin
                    line_q[wr_chunk*FILL_W +: FILL_W] <= wr_data;
                end
                if (tag_we) begin
                    tag_q <= wr_tag;
                end
            end
        end

        assign line_w[s] = line_q;
        assign tag_w[s]  = tag_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush_all) begin
            valid_q <= '0;
        end else begin
            if (invalidate) begin
                valid_q[wr_index] <= 1'b0;
            end
            if (validate) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    assign valid   = valid_q[rd_index];
    assign match   = valid && (tag_w[rd_index] == rd_tag);
    assign rd_line = line_w[rd_index];
    assign word    = rd_line[rd_word*RV +: RV];

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with nibble/byte line fill
// Ports: clk, reset_n; fetch paddr/req -> hit, rdata; fill pull/tag/busy with beats on
//        dread qualified by wstrobe_d; flush_all invalidates every line and aborts a fill.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int RV                     = 16,
    parameter int PA                     = 22,
    parameter int LINE_LENGTH            = 4,
    parameter int NSETS                  = 4,
    parameter int NWAYS                  = 2,
    parameter int FILL_W                 = 4,
    parameter int USE_LATCHES_FOR_ICACHE = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [PA-1:1]                   paddr,
    input  logic                            req,
    input  logic [FILL_W-1:0]               dread,
    input  logic                            wstrobe_d,
    input  logic                            flush_all,
    output logic                            hit,
    output logic                            pull,
    output logic [PA-1:$clog2(LINE_LENGTH)] tag,
    output logic [RV-1:0]                   rdata,
    output logic                            busy
);

    localparam int OW    = icache_off_w(LINE_LENGTH);
    localparam int IW    = $clog2(NSETS);
    localparam int IXW   = icache_idx_w(NSETS);
    localparam int LW    = PA - OW;
    localparam int TW    = LW - IW;
    localparam int RB    = $clog2(RV / 8);
    localparam int WDW   = min1(OW - RB);
    localparam int BEATS = icache_beats(LINE_LENGTH, FILL_W);
    localparam int BW    = min1($clog2(BEATS));

    icache_state_e state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [LW-1:0] fill_line_q;
    logic          fill_way_q;

    logic [PA-1:0]  byte_addr;
    logic [LW-1:0]  p_line;
    logic [TW-1:0]  p_tag;
    logic [IXW-1:0] p_index;
    logic [IXW-1:0] fill_index;
    logic [IXW-1:0] wr_index;
    logic [WDW-1:0] p_word;
    logic [BW-1:0]  wr_chunk;

    logic start_fill, beat_wr, last_beat;
    logic victim, hit_way;

    logic [NWAYS-1:0] way_match;
    logic [NWAYS-1:0] way_valid;
    logic [RV-1:0]    way_word [NWAYS];
    logic [RV-1:0]    rdata_c;

    assign byte_addr = {paddr, 1'b0};
    assign p_line    = byte_addr[PA-1:OW];
    assign p_tag     = p_line[LW-1:IW];

    if (IW > 0) begin : g_index
        assign p_index    = p_line[IXW-1:0];
        assign fill_index = fill_line_q[IXW-1:0];
    end else begin : g_no_index
        assign p_index    = '0;
        assign fill_index = '0;
    end

    if (OW > RB) begin : g_word_sel
        assign p_word = byte_addr[OW-1:RB];
    end else begin : g_one_word
        assign p_word = '0;
    end

    // Nibble fills arrive high nibble first within each byte.
    assign wr_chunk = (FILL_W == 4) ? (beat_q ^ BW'(1)) : beat_q;
    assign wr_index = (state_q == ST_FILL) ? fill_index : p_index;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
        if (start_fill) begin
            fill_line_q <= p_line;
            fill_way_q  <= victim;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        start_fill = 1'b0;
        beat_wr    = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !hit && !flush_all) begin
                    start_fill = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                // A flush in the final-beat cycle wins: nothing is written or validated.
                beat_wr   = wstrobe_d && !flush_all;
                last_beat = beat_wr && (beat_q == BW'(BEATS - 1));
                if (flush_all || last_beat) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else if (beat_wr) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        logic sel;
        assign sel = (fill_way_q == 1'(w));

        icache_way #(
            .RV                     (RV),
            .PA                     (PA),
            .LINE_LENGTH            (LINE_LENGTH),
            .NSETS                  (NSETS),
            .FILL_W                 (FILL_W),
            .USE_LATCHES_FOR_ICACHE (USE_LATCHES_FOR_ICACHE)
        ) u_way (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush_all  (flush_all),
            .rd_index   (p_index),
            .rd_tag     (p_tag),
            .rd_word    (p_word),
            .wr_index   (wr_index),
            .wr_en      (beat_wr && sel),
            .wr_chunk   (wr_chunk),
            .wr_data    (dread),
            .wr_tag     (fill_line_q[LW-1:IW]),
            .validate   (last_beat && sel),
            .invalidate (start_fill && (victim == 1'(w))),
            .match      (way_match[w]),
            .valid      (way_valid[w]),
            .word       (way_word[w])
        );
    end

    if (NWAYS == 2) begin : g_mru
        logic [NSETS-1:0] mru_q;

        assign hit_way = way_match[1];
        assign victim  = !way_valid[0] ? 1'b0 :
                         !way_valid[1] ? 1'b1 : !mru_q[p_index];

        always_ff @(posedge clk) begin
            if (!reset_n || flush_all) begin
                mru_q <= '0;
            end else begin
                if (hit) begin
                    mru_q[p_index] <= hit_way;
                end
                if (last_beat) begin
                    mru_q[fill_index] <= fill_way_q;
                end
            end
        end
    end else begin : g_direct
        assign hit_way = 1'b0;
        assign victim  = 1'b0;
    end

    always_comb begin
        rdata_c = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (way_match[w]) begin
                rdata_c = rdata_c | way_word[w];
            end
        end
    end

    assign hit   = req && (|way_match);
    assign rdata = hit ? rdata_c : '0;
    assign pull  = (state_q == ST_FILL);
    assign busy  = (state_q == ST_FILL);
    assign tag   = (state_q == ST_FILL) ? fill_line_q : p_line;

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter RV, default 16: fetch word width in bits, 16 or 32.
REQ-002 Parameter PA, default 22: physical address width in bits.
REQ-003 Parameter LINE_LENGTH, default 4: line size in bytes, a power of 2, at least RV/8.
REQ-004 Parameter NSETS, default 4: number of sets, a power of 2.
REQ-005 Parameter NWAYS, default 2: associativity, 1 or 2.
REQ-006 Parameter FILL_W, default 4: fill beat width in bits, 4 or 8.
REQ-007 Parameter USE_LATCHES_FOR_ICACHE, default 1: 1 selects clk-low transparent latches for data/tag storage; 0 selects posedge flops.
REQ-008 clk  in  1  the only clock; all state changes on its posedge.
REQ-009 reset_n  in  1  synchronous, active-low reset.
REQ-010 paddr  in  PA-1:1  fetch halfword address.
REQ-011 req  in  1  fetch valid.
REQ-012 dread  in  FILL_W  fill beat data.
REQ-013 wstrobe_d  in  1  fill beat valid.
REQ-014 flush_all  in  1  invalidate the whole cache.
REQ-015 hit  out  1  the word addressed by paddr is present.
REQ-016 pull  out  1  line fill request.
REQ-017 tag  out  PA-1:log2(LINE_LENGTH)  line address being filled.
REQ-018 rdata  out  RV  fetched word.
REQ-019 busy  out  1  fill in progress.

Function
REQ-020 hit SHALL be combinational: req AND (some way of set paddr[log2(LINE_LENGTH*NSETS)-1:log2(LINE_LENGTH)] is valid with a stored tag equal to paddr[PA-1:log2(LINE_LENGTH*NSETS)]).
REQ-021 rdata SHALL be the little-endian RV-bit word of the hitting line selected by paddr[log2(LINE_LENGTH)-1:log2(RV/8)], and 0 when hit=0.
REQ-022 The FSM SHALL have two states: IDLE and FILL.
- IDLE to FILL: on a cycle with req AND NOT hit AND NOT flush_all.
- FILL to IDLE: on the final beat, or on flush_all.
REQ-023 On entry to FILL the block SHALL latch the line address and a victim way; later paddr changes SHALL NOT affect that fill.
REQ-024 Victim selection: the lowest-numbered invalid way; if none, the way not marked most recently used (MRU) in that set.
REQ-025 pull and busy SHALL be 1 exactly while in FILL; tag SHALL be the latched line address in FILL and {ptag,pindex} of paddr in IDLE.
REQ-026 Each wstrobe_d cycle in FILL SHALL write one beat; BEATS = LINE_LENGTH*8/FILL_W; a beat counter runs 0..BEATS-1 and returns to 0 on completion or abort.
REQ-027 Beat order, FILL_W=4: bytes ascending, high nibble first within each byte (beat n writes nibble n^1).
REQ-028 Beat order, FILL_W=8: bytes ascending.
REQ-029 wstrobe_d may have gaps; wstrobe_d in IDLE SHALL be ignored.
REQ-030 On the final beat the block SHALL write the tag, set the way valid and mark it MRU; hit SHALL be possible from the next cycle.
REQ-031 A hit SHALL mark the hitting way MRU for its set.
REQ-032 flush_all SHALL clear all valid and MRU bits in the next cycle; in FILL it SHALL abort the fill, leaving the victim way invalid, and pull SHALL drop the next cycle.
REQ-033 flush_all SHALL take priority over a simultaneous final beat, which leaves the line invalid.
REQ-034 With NWAYS=1 the MRU logic SHALL be absent and the single way is always the victim.

Reset
REQ-035 While reset_n=0 at posedge: state IDLE, beat counter 0, all valid/MRU bits 0; hence hit=0, pull=0, busy=0, rdata=0.
REQ-036 Data and tag arrays SHALL NOT be reset.
REQ-037 Reset mid-fill SHALL abort the fill with no line validated.

Structure
REQ-038 Package icache_pkg SHALL hold the FSM state enum and localparam helpers (BEATS, index/offset widths).
REQ-039 Sub-module icache_way: one instance per way, holding data, tag and valid storage plus the USE_LATCHES_FOR_ICACHE choice, exposing match/valid/word.

Verification (defaults; addresses are byte addresses)
REQ-040 Cold miss at 0x10 -> pull=1, tag=0x4; beats 1,2,3,4,5,6,7,8 -> next cycle hit=1, rdata=0x3412 at 0x10 and 0x7856 at 0x12.
REQ-041 Fill 0x10 then 0x50 (set 0) -> both hit; access 0x10, then miss 0x90 -> 0x50 evicted: 0x10 hits, 0x50 misses.
REQ-042 flush_all after 3 beats -> pull=0 next cycle; 0x10 misses, and a refill from beat 0 with the values of REQ-040 gives rdata=0x3412.
REQ-043 reset_n=0 for one cycle after 5 beats -> hit=0, pull=0; a following full fill is correct.
REQ-044 The REQ-040 fill with one idle cycle between each beat -> identical rdata.
REQ-045 FILL_W=8: beats 0x12,0x34,0x56,0x78 -> rdata=0x3412 at 0x10.
